// File: rtl/pllvr_ctrl_pkg.sv
// Shared types and helpers for the PLLVR sequencing controller.
`timescale 1ns/1ps
package pllvr_ctrl_pkg;

  // Width of every PLLVR divider code and dynamic select bus.
  localparam int DIV_W = 6;

  // Controller phases: reset hold, lock wait, locked run, retries exhausted.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    FAIL = 2'd3
  } state_e;

  // The PLLVR dynamic select pins take the inverted divider code.
  function automatic logic [DIV_W-1:0] to_dsel(input logic [DIV_W-1:0] code);
    return ~code;
  endfunction

endpackage

// File: rtl/pllvr_ctrl_if.sv
// Divider reconfiguration request bus.
// Handshake: the master raises cfg_valid with stable codes and keeps them until
// a clock edge where cfg_valid && cfg_ready are both high; that edge is the
// transfer. The slave may hold cfg_ready low indefinitely; cfg_valid must not
// depend on cfg_ready.
`timescale 1ns/1ps
interface pllvr_ctrl_if;
  import pllvr_ctrl_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_idiv;
  logic [DIV_W-1:0] cfg_fbdiv;
  logic [DIV_W-1:0] cfg_odiv;

  modport master (
    output cfg_valid,
    output cfg_idiv,
    output cfg_fbdiv,
    output cfg_odiv,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_idiv,
    input  cfg_fbdiv,
    input  cfg_odiv,
    output cfg_ready
  );

endinterface

// File: rtl/pllvr_lock_filt.sv
// Synchronises the asynchronous PLL LOCK and qualifies it with a saturating
// count of consecutive high samples.
`timescale 1ns/1ps
module pllvr_lock_filt #(
  parameter int LOCK_FILT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic lock_i,
  input  logic clr_i,
  output logic lock_s_o,
  output logic lock_ok_o
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILT);

  logic          sync1_q;
  logic          sync2_q;
  logic [FW-1:0] cnt_q;
  logic [FW-1:0] cnt_d;

  // Two-flop synchroniser for the asynchronous lock pin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= lock_i;
      sync2_q <= sync1_q;
    end
  end

  // Stable-count next value: restart on clear or any low sample, else saturate up.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != FILT_MAX) begin
      cnt_d = cnt_q + FW'(1);
    end
  end

  // Stable-count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lock_s_o  = sync2_q;
  assign lock_ok_o = (cnt_q == FILT_MAX);

endmodule

// File: rtl/pllvr_ctrl.sv
// PLLVR reset sequencing, lock supervision with retry, and runtime divider
// reconfiguration. Runs entirely on the reference clock.
`timescale 1ns/1ps
module pllvr_ctrl
  import pllvr_ctrl_pkg::*;
#(
  parameter int IDIV_DEF     = 2,
  parameter int FBDIV_DEF    = 7,
  parameter int ODIV_DEF     = 16,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_FILT    = 256,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3,
  parameter int RETRY_W      = 2
) (
  input  logic               clkin,
  input  logic               reset_n,
  pllvr_ctrl_if.slave        cfg,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic [DIV_W-1:0]   pll_idsel,
  output logic [DIV_W-1:0]   pll_fbdsel,
  output logic [DIV_W-1:0]   pll_odsel,
  output logic               sys_reset_n,
  output logic               locked,
  output logic               fail,
  output logic [RETRY_W-1:0] retries,
  output state_e             dbg_state
);

  localparam int CNT_MAX = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  if (MAX_RETRY > (2 ** RETRY_W) - 1) begin : g_retry_range_chk
    $error("pllvr_ctrl: MAX_RETRY does not fit in RETRY_W bits");
  end
  if (RST_HOLD < 1 || LOCK_FILT < 1 || MAX_RETRY < 1) begin : g_param_chk
    $error("pllvr_ctrl: RST_HOLD, LOCK_FILT and MAX_RETRY must be at least 1");
  end

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               pll_reset_q;
  logic [DIV_W-1:0]   idsel_q;
  logic [DIV_W-1:0]   fbdsel_q;
  logic [DIV_W-1:0]   odsel_q;
  logic               sys_rst_n_q;
  logic               locked_q;
  logic               fail_q;
  logic               cfg_ready_q;
  logic [RETRY_W-1:0] retries_q;
  logic [RETRY_W-1:0] retries_inc_d;

  logic lock_s;
  logic lock_ok;
  logic filt_clr;
  logic cfg_fire;

  // The filter only accumulates inside WAIT, so each attempt starts from zero.
  assign filt_clr = (state_q != WAIT);
  assign cfg_fire = cfg.cfg_valid && cfg_ready_q;

  pllvr_lock_filt #(
    .LOCK_FILT (LOCK_FILT)
  ) u_lock_filt (
    .clk_i     (clkin),
    .rst_ni    (reset_n),
    .lock_i    (pll_lock),
    .clr_i     (filt_clr),
    .lock_s_o  (lock_s),
    .lock_ok_o (lock_ok)
  );

  // Saturating increment of the failed-attempt count.
  always_comb begin
    retries_inc_d = retries_q;
    if (retries_q != RETRY_SAT) begin
      retries_inc_d = retries_q + RETRY_W'(1);
    end
  end

  // Sequencer: all outputs are registered and change with the state.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      pll_reset_q <= 1'b1;
      idsel_q     <= to_dsel(DIV_W'(IDIV_DEF));
      fbdsel_q    <= to_dsel(DIV_W'(FBDIV_DEF));
      odsel_q     <= to_dsel(DIV_W'(ODIV_DEF));
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
      retries_q   <= '0;
    end else if (cfg_fire) begin
      // New codes land on the same edge that raises pll_reset, so the PLL
      // never sees a select change while running. Wins over lock loss.
      state_q     <= HOLD;
      cnt_q       <= '0;
      pll_reset_q <= 1'b1;
      idsel_q     <= to_dsel(cfg.cfg_idiv);
      fbdsel_q    <= to_dsel(cfg.cfg_fbdiv);
      odsel_q     <= to_dsel(cfg.cfg_odiv);
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
      retries_q   <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q     <= WAIT;
            cnt_q       <= '0;
            pll_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (lock_ok) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            retries_q   <= '0;
            locked_q    <= 1'b1;
            cfg_ready_q <= 1'b1;
          end else if (cnt_q == WAIT_LAST) begin
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            retries_q   <= retries_inc_d;
            if (retries_inc_d == RETRY_MAX) begin
              state_q     <= FAIL;
              fail_q      <= 1'b1;
              cfg_ready_q <= 1'b1;
            end else begin
              state_q <= HOLD;
            end
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
          end else begin
            sys_rst_n_q <= 1'b1;
          end
        end
        default: begin
          // FAIL: parked with the PLL in reset until a new request or reset_n.
          pll_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign pll_reset     = pll_reset_q;
  assign pll_idsel     = idsel_q;
  assign pll_fbdsel    = fbdsel_q;
  assign pll_odsel     = odsel_q;
  assign sys_reset_n   = sys_rst_n_q;
  assign locked        = locked_q;
  assign fail          = fail_q;
  assign retries       = retries_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pllvr_ctrl.sv
// Bench for pllvr_ctrl: directed scenarios followed by randomized lock and
// reconfiguration traffic, checked against a phase-level reference model.
`timescale 1ns/1ps
module tb_pllvr_ctrl;
  import pllvr_ctrl_pkg::*;

  localparam int IDIV_DEF     = 2;
  localparam int FBDIV_DEF    = 7;
  localparam int ODIV_DEF     = 16;
  localparam int RST_HOLD     = 4;
  localparam int LOCK_FILT    = 8;
  localparam int LOCK_TIMEOUT = 64;
  localparam int MAX_RETRY    = 2;
  localparam int RETRY_W      = 2;
  localparam int VW           = 25;

  localparam int P_HOLD = 0;
  localparam int P_WAIT = 1;
  localparam int P_RUN  = 2;
  localparam int P_FAIL = 3;

  // {pll_reset, idsel, fbdsel, odsel, sys_reset_n, locked, fail, cfg_ready, retries}
  localparam logic [VW-1:0] RESET_VEC = {1'b1, 6'h3D, 6'h38, 6'h2F, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

  // ---------------- clock / reset ----------------
  logic               clkin;
  logic               reset_n;
  logic               pll_lock;
  logic               pll_reset;
  logic [5:0]         pll_idsel;
  logic [5:0]         pll_fbdsel;
  logic [5:0]         pll_odsel;
  logic               sys_reset_n;
  logic               locked;
  logic               fail;
  logic [RETRY_W-1:0] retries;
  state_e             dbg_state;

  pllvr_ctrl_if cfg_bus ();

  pllvr_ctrl #(
    .IDIV_DEF     (IDIV_DEF),
    .FBDIV_DEF    (FBDIV_DEF),
    .ODIV_DEF     (ODIV_DEF),
    .RST_HOLD     (RST_HOLD),
    .LOCK_FILT    (LOCK_FILT),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .MAX_RETRY    (MAX_RETRY),
    .RETRY_W      (RETRY_W)
  ) dut (
    .clkin       (clkin),
    .reset_n     (reset_n),
    .cfg         (cfg_bus.slave),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .pll_idsel   (pll_idsel),
    .pll_fbdsel  (pll_fbdsel),
    .pll_odsel   (pll_odsel),
    .sys_reset_n (sys_reset_n),
    .locked      (locked),
    .fail        (fail),
    .retries     (retries),
    .dbg_state   (dbg_state)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [VW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  function automatic logic [VW-1:0] act_vec();
    return {pll_reset, pll_idsel, pll_fbdsel, pll_odsel, sys_reset_n, locked, fail,
            cfg_bus.cfg_ready, retries};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase-level view: outputs are functions of the phase and time spent in it.
  int         m_phase;
  int         m_el;
  bit         m_hist[$];
  int         m_stable;
  int         m_ret;
  logic [5:0] m_id;
  logic [5:0] m_fb;
  logic [5:0] m_od;

  task automatic model_reset();
    m_phase  = P_HOLD;
    m_el     = 0;
    m_hist   = {1'b0, 1'b0};
    m_stable = 0;
    m_ret    = 0;
    m_id     = 6'(IDIV_DEF);
    m_fb     = 6'(FBDIV_DEF);
    m_od     = 6'(ODIV_DEF);
  endtask

  function automatic logic [VW-1:0] model_out();
    logic rst_o, srn_o, lk_o, fl_o, rdy_o;
    rst_o = (m_phase == P_HOLD) || (m_phase == P_FAIL);
    lk_o  = (m_phase == P_RUN);
    srn_o = (m_phase == P_RUN) && (m_el >= 1);
    fl_o  = (m_phase == P_FAIL);
    rdy_o = lk_o || fl_o;
    return {rst_o, ~m_id, ~m_fb, ~m_od, srn_o, lk_o, fl_o, rdy_o, 2'(m_ret)};
  endfunction

  task automatic model_edge(input bit lk, input bit cv, input logic [5:0] ci,
                            input logic [5:0] cf, input logic [5:0] co, output bit accepted);
    bit ls;
    bit ok;
    bit fire;
    int nxt;
    ls = m_hist.pop_front();
    m_hist.push_back(lk);
    ok = (m_stable >= LOCK_FILT);
    if (m_phase == P_WAIT) m_stable = ls ? ((m_stable < LOCK_FILT) ? m_stable + 1 : m_stable) : 0;
    else m_stable = 0;
    fire = cv && (m_phase == P_RUN || m_phase == P_FAIL);
    nxt  = m_phase;
    if (fire) begin
      m_id  = ci;
      m_fb  = cf;
      m_od  = co;
      m_ret = 0;
      nxt   = P_HOLD;
    end else begin
      case (m_phase)
        P_HOLD: if (m_el == RST_HOLD - 1) nxt = P_WAIT;
        P_WAIT: begin
          if (ok) begin
            nxt   = P_RUN;
            m_ret = 0;
          end else if (m_el == LOCK_TIMEOUT - 1) begin
            m_ret = (m_ret < 3) ? m_ret + 1 : 3;
            nxt   = (m_ret == MAX_RETRY) ? P_FAIL : P_HOLD;
          end
        end
        P_RUN: if (!ls) nxt = P_HOLD;
        default: ;
      endcase
    end
    m_el     = (nxt != m_phase) ? 0 : m_el + 1;
    m_phase  = nxt;
    accepted = fire;
  endtask

  // ---------------- driver ----------------
  bit         req_pending;
  logic [5:0] req_i;
  logic [5:0] req_f;
  logic [5:0] req_o;

  task automatic request(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
    req_pending = 1'b1;
    req_i = i;
    req_f = f;
    req_o = o;
  endtask

  // Called at a negedge: drive inputs for the coming edge, predict its result.
  task automatic step(input bit lk);
    bit acc;
    pll_lock            = lk;
    cfg_bus.cfg_valid   = req_pending;
    cfg_bus.cfg_idiv    = req_i;
    cfg_bus.cfg_fbdiv   = req_f;
    cfg_bus.cfg_odiv    = req_o;
    model_edge(lk, req_pending, req_i, req_f, req_o, acc);
    if (acc) req_pending = 1'b0;
    exp_q.push_back(model_out());
    exp_cyc_q.push_back(cyc + 1);
    @(posedge clkin);
    @(negedge clkin);
    cyc++;
  endtask

  task automatic steps(input int n, input bit lk);
    for (int k = 0; k < n; k++) step(lk);
  endtask

  task automatic cold_start(input bit mid);
    reset_n           = 1'b0;
    pll_lock          = 1'b0;
    req_pending       = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    if (mid) begin
      #1;
      check("async_reset_outputs", 32'(act_vec()), 32'(RESET_VEC));
    end
    repeat (3) @(negedge clkin);
    model_reset();
    check("reset_state", 32'(act_vec()), 32'(RESET_VEC));
    reset_n = 1'b1;
    cyc     = 0;
    for (int k = 0; k < 30; k++) begin
      if (cyc == 3)  check("pll_reset_high_c3", 32'(pll_reset), 32'd1);
      if (cyc == 4)  check("pll_reset_low_c4", 32'(pll_reset), 32'd0);
      if (cyc == 19) check("locked_low_c19", 32'(locked), 32'd0);
      if (cyc == 20) begin
        check("locked_c20", 32'(locked), 32'd1);
        check("sys_reset_n_low_c20", 32'(sys_reset_n), 32'd0);
      end
      if (cyc == 21) begin
        check("sys_reset_n_c21", 32'(sys_reset_n), 32'd1);
        check("fbdsel_default", 32'(pll_fbdsel), 32'h38);
        check("idsel_default", 32'(pll_idsel), 32'h3D);
      end
      step(cyc + 1 >= 10);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clkin) begin
    logic [VW-1:0] e;
    int            c;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = exp_cyc_q.pop_front();
      checks++;
      if (act_vec() !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %h expected %h", c, act_vec(), e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int mode;
    int len;
    bit lk;
    reset_n           = 1'b0;
    pll_lock          = 1'b0;
    req_pending       = 1'b0;
    req_i             = '0;
    req_f             = '0;
    req_o             = '0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_idiv  = '0;
    cfg_bus.cfg_fbdiv = '0;
    cfg_bus.cfg_odiv  = '0;

    // Cold start with lock arriving at cycle 10.
    cold_start(1'b0);

    // Single-cycle lock loss in RUN, then re-lock.
    step(1'b0);
    steps(30, 1'b1);

    // Glitch inside WAIT restarts the filter.
    steps(10, 1'b0);
    steps(5, 1'b1);
    step(1'b0);
    steps(25, 1'b1);

    // Reconfigure while running.
    check("cfg_ready_in_run", 32'(cfg_bus.cfg_ready), 32'd1);
    request(6'd0, 6'd3, 6'd8);
    step(1'b1);
    check("reconf_idsel", 32'(pll_idsel), 32'h3F);
    check("reconf_fbdsel", 32'(pll_fbdsel), 32'h3C);
    check("reconf_odsel", 32'(pll_odsel), 32'h37);
    check("reconf_pll_reset", 32'(pll_reset), 32'd1);
    check("reconf_locked_drop", 32'(locked), 32'd0);
    steps(30, 1'b1);

    // Lock never returns: two timeouts, then FAIL.
    steps(80, 1'b0);
    check("retries_after_first_timeout", 32'(retries), 32'd1);
    steps(80, 1'b0);
    check("fail_flag", 32'(fail), 32'd1);
    check("fail_pll_reset", 32'(pll_reset), 32'd1);
    check("fail_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check("fail_retries", 32'(retries), 32'd2);

    // Leave FAIL through a request, then reset mid-WAIT with retries=1.
    request(6'(IDIV_DEF), 6'(FBDIV_DEF), 6'(ODIV_DEF));
    step(1'b0);
    check("fail_exit", 32'(fail), 32'd0);
    steps(73, 1'b0);
    check("retries_before_reset", 32'(retries), 32'd1);
    cold_start(1'b1);

    // Randomized lock behaviour and reconfiguration traffic.
    for (int s = 0; s < 50; s++) begin
      mode = $urandom_range(0, 9);
      len  = $urandom_range(5, 120);
      for (int k = 0; k < len; k++) begin
        if (mode < 6)      lk = ($urandom_range(0, 199) != 0);
        else if (mode < 8) lk = 1'($urandom_range(0, 1));
        else               lk = 1'b0;
        if (!req_pending && $urandom_range(0, 39) == 0)
          request(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        step(lk);
      end
    end

    @(posedge clkin);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
